// File: rtl/seg_scan_reader.sv
// seg_scan_reader
// Snoops a multiplexed, active-low, common-anode 7-segment display bus and
// recovers the BCD code shown on each digit. Each (segment, digit) pair must
// hold for STABLE_CNT synchronized samples before it is accepted. Once every
// digit has been accepted, the collected frame is published for one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   seg_n       segments {a,b,c,d,e,f,g}, a at bit 6, 0 = lit (async input)
//   dig_sel     one-hot digit enable, bit i selects digit i (async input)
//   bcd_out     published frame, digit i at [4i+3:4i]
//   digit_err   per-digit illegal-pattern flag for the published frame
//   frame_valid one-cycle strobe when bcd_out/digit_err update
module seg_scan_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  localparam logic [3:0]        CNT_SAT = 4'(STABLE_CNT - 1);
  localparam logic [DIGITS-1:0] DIG_ONE = DIGITS'(1);

  // Returns {err, code} for one segment pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0000001: res = {1'b0, 4'h0};
      7'b1001111: res = {1'b0, 4'h1};
      7'b0010010: res = {1'b0, 4'h2};
      7'b0000110: res = {1'b0, 4'h3};
      7'b1001100: res = {1'b0, 4'h4};
      7'b0100100: res = {1'b0, 4'h5};
      7'b0100000: res = {1'b0, 4'h6};
      7'b0001111: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0000100: res = {1'b0, 4'h9};
      7'b1111111: res = {1'b0, 4'hA};
      default:    res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  logic [6:0]          seg_meta_r, s_seg_r, prev_seg_r;
  logic [DIGITS-1:0]   dig_meta_r, s_dig_r, prev_dig_r;
  logic [3:0]          stab_cnt_r, cnt_next_s;
  logic                taken_r;
  logic                dig_onehot_s, same_s, accept_s, full_s;
  logic [4:0]          decoded_s;
  logic [4*DIGITS-1:0] shadow_bcd_r, shadow_bcd_next_s;
  logic [DIGITS-1:0]   shadow_err_r, shadow_err_next_s;
  logic [DIGITS-1:0]   seen_r, seen_base_s, seen_upd_s;
  state_t              state_r;

  // Two-flop synchronizers for the asynchronous display bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta_r <= 7'd0;
      s_seg_r    <= 7'd0;
      dig_meta_r <= '0;
      s_dig_r    <= '0;
    end else begin
      seg_meta_r <= seg_n;
      s_seg_r    <= seg_meta_r;
      dig_meta_r <= dig_sel;
      s_dig_r    <= dig_meta_r;
    end
  end

  // Stability detection and accept decision on the synchronized pair.
  always_comb begin
    dig_onehot_s = (s_dig_r != '0) && ((s_dig_r & (s_dig_r - DIG_ONE)) == '0);
    same_s       = dig_onehot_s && (s_seg_r == prev_seg_r) && (s_dig_r == prev_dig_r);
    if (!same_s) begin
      cnt_next_s = 4'd0;
    end else if (stab_cnt_r == CNT_SAT) begin
      cnt_next_s = CNT_SAT;
    end else begin
      cnt_next_s = stab_cnt_r + 4'd1;
    end
    // Counting the current sample, the dwell has now lasted STABLE_CNT samples.
    accept_s  = (cnt_next_s == CNT_SAT) && !taken_r;
    decoded_s = decode_seg(s_seg_r);
  end

  // Shadow frame with the current accept merged in; latest accept wins.
  always_comb begin
    shadow_bcd_next_s = shadow_bcd_r;
    shadow_err_next_s = shadow_err_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (accept_s && s_dig_r[i]) begin
        shadow_bcd_next_s[4*i +: 4] = decoded_s[3:0];
        shadow_err_next_s[i]        = decoded_s[4];
      end else begin
        shadow_bcd_next_s[4*i +: 4] = shadow_bcd_r[4*i +: 4];
        shadow_err_next_s[i]        = shadow_err_r[i];
      end
    end
  end

  // Coverage tracking; a publish cycle starts from an empty seen set so an
  // accept landing there counts toward the next frame.
  always_comb begin
    if (state_r == ST_PUBLISH) begin
      seen_base_s = '0;
    end else begin
      seen_base_s = seen_r;
    end
    if (accept_s) begin
      seen_upd_s = seen_base_s | s_dig_r;
    end else begin
      seen_upd_s = seen_base_s;
    end
    full_s = accept_s && (seen_upd_s == '1);
  end

  // Previous-sample registers, dwell counter and once-per-dwell flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_seg_r <= 7'd0;
      prev_dig_r <= '0;
      stab_cnt_r <= 4'd0;
      taken_r    <= 1'b0;
    end else begin
      prev_seg_r <= s_seg_r;
      prev_dig_r <= s_dig_r;
      stab_cnt_r <= cnt_next_s;
      if (accept_s) begin
        taken_r <= 1'b1;
      end else if (cnt_next_s == 4'd0) begin
        taken_r <= 1'b0;
      end else begin
        taken_r <= taken_r;
      end
    end
  end

  // Shadow frame storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd_r <= '0;
      shadow_err_r <= '0;
    end else begin
      shadow_bcd_r <= shadow_bcd_next_s;
      shadow_err_r <= shadow_err_next_s;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      seen_r      <= '0;
      bcd_out     <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else if (full_s) begin
      state_r     <= ST_PUBLISH;
      seen_r      <= '0;
      bcd_out     <= shadow_bcd_next_s;
      digit_err   <= shadow_err_next_s;
      frame_valid <= 1'b1;
    end else begin
      state_r     <= (seen_upd_s == '0) ? ST_IDLE : ST_COLLECT;
      seen_r      <= seen_upd_s;
      bcd_out     <= bcd_out;
      digit_err   <= digit_err;
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
module tb_seg_scan_reader;

  localparam int DIGITS = 4;
  localparam int SC     = 3;

  localparam logic [6:0] PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'b1111111;
  logic [3:0]  dig_sel = 4'b0000;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_sel(dig_sel),
    .bcd_out(bcd_out), .digit_err(digit_err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (dwell level) ----------------
  typedef struct { logic [15:0] bcd; logic [3:0] err; } frame_t;
  frame_t exp_q[$];

  logic [3:0] m_code [4];
  logic [3:0] m_err;
  logic [3:0] m_seen;
  logic [6:0] run_seg;
  logic [3:0] run_dig;
  int         run_len;
  bit         run_ok;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (PAT[i] == p) return {1'b0, 4'(i)};
    end
    if (p == BLANK) return {1'b0, 4'hA};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
    m_err  = 4'b0;
    m_seen = 4'b0;
    run_ok = 1'b0;
    run_len = 0;
  endtask

  task automatic model_dwell(input logic [6:0] seg, input logic [3:0] dig, input int len);
    int old;
    logic [4:0] d;
    frame_t f;
    if (run_ok && seg == run_seg && dig == run_dig) begin
      old = run_len;
      run_len = run_len + len;
    end else begin
      old = 0;
      run_len = len;
      run_seg = seg;
      run_dig = dig;
      run_ok = 1'b1;
    end
    if ($countones(dig) == 1 && old < SC && run_len >= SC) begin
      d = ref_decode(seg);
      for (int i = 0; i < 4; i++) begin
        if (dig[i]) begin
          m_code[i] = d[3:0];
          m_err[i]  = d[4];
          m_seen[i] = 1'b1;
        end
      end
      if (m_seen == 4'b1111) begin
        f.bcd = {m_code[3], m_code[2], m_code[1], m_code[0]};
        f.err = m_err;
        exp_q.push_back(f);
        m_seen = 4'b0;
      end
    end
  endtask

  // ---------------- output monitor ----------------
  logic [15:0] prev_bcd = 16'h0;
  logic [3:0]  prev_err = 4'h0;
  logic        prev_fv = 1'b0;

  always @(negedge clk) begin
    frame_t f;
    if (rst) begin
      prev_fv = 1'b0;
    end else if (frame_valid) begin
      pulses++;
      checks++;
      if (prev_fv) begin
        errors++;
        $display("FAIL fv_back_to_back: frame_valid high two cycles at %0t", $time);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got bcd=%h err=%b, required no frame", bcd_out, digit_err);
      end else begin
        f = exp_q.pop_front();
        if (bcd_out !== f.bcd || digit_err !== f.err) begin
          errors++;
          $display("FAIL model_frame: got bcd=%h err=%b, required bcd=%h err=%b",
                   bcd_out, digit_err, f.bcd, f.err);
        end
      end
    end else begin
      checks++;
      if (bcd_out !== prev_bcd || digit_err !== prev_err) begin
        errors++;
        $display("FAIL hold: outputs changed without frame_valid, got %h/%b, required %h/%b",
                 bcd_out, digit_err, prev_bcd, prev_err);
      end
    end
    prev_bcd = bcd_out;
    prev_err = digit_err;
    prev_fv  = frame_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic [6:0] seg, input logic [3:0] dig, input int len);
    seg_n   = seg;
    dig_sel = dig;
    model_dwell(seg, dig, len);
    repeat (len) @(negedge clk);
  endtask

  task automatic idle(input int len);
    apply(BLANK, 4'b0000, len);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  typedef struct {
    logic [6:0]  seg [4];
    int          len;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs [4];
  int   p0;

  initial begin
    vecs[0] = '{'{7'b0000110, 7'b1001100, 7'b0100100, 7'b0000100}, 8, 16'h9543, 4'b0000};
    vecs[1] = '{'{7'b1111111, 7'b1001111, 7'b1111110, 7'b0001111}, 8, 16'h7F1A, 4'b0100};
    vecs[2] = '{'{7'b0000001, 7'b0000000, 7'b0001111, 7'b0100000}, 5, 16'h6780, 4'b0000};
    vecs[3] = '{'{7'b0010010, 7'b1111111, 7'b0110000, 7'b0000100}, SC, 16'h9FA2, 4'b0100};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_err", 32'(digit_err), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    rst = 1'b0;
    idle(4);

    // Table-driven clean frames, digits scanned 0..3.
    for (int v = 0; v < 4; v++) begin
      p0 = pulses;
      for (int d = 0; d < 4; d++) apply(vecs[v].seg[d], 4'b0001 << d, vecs[v].len);
      idle(6);
      check($sformatf("vec%0d_pulses", v), 32'(pulses - p0), 32'd1);
      check($sformatf("vec%0d_bcd", v), 32'(bcd_out), 32'(vecs[v].exp_bcd));
      check($sformatf("vec%0d_err", v), 32'(digit_err), 32'(vecs[v].exp_err));
    end

    // Glitch rejection: a 2-sample 8 on digit 1 must not be accepted.
    p0 = pulses;
    apply(7'b0000110, 4'b0001, 8);
    apply(7'b0000000, 4'b0010, 2);
    apply(7'b1001100, 4'b0010, 8);
    apply(7'b0100100, 4'b0100, 8);
    apply(7'b0000100, 4'b1000, 8);
    idle(6);
    check("glitch_pulses", 32'(pulses - p0), 32'd1);
    check("glitch_bcd", 32'(bcd_out), 32'h9543);

    // Bad enables between partial coverage; seen must survive them.
    p0 = pulses;
    apply(7'b0001111, 4'b0001, 8);
    apply(7'b0000000, 4'b0010, 8);
    apply(7'b0000001, 4'b0000, 10);
    apply(7'b0000001, 4'b0110, 10);
    check("badsel_no_frame", 32'(pulses - p0), 32'd0);
    apply(7'b1001111, 4'b0100, 8);
    idle(6);
    check("badsel_still_partial", 32'(pulses - p0), 32'd0);
    apply(7'b0010010, 4'b1000, 8);
    idle(6);
    check("badsel_pulses", 32'(pulses - p0), 32'd1);
    check("badsel_bcd", 32'(bcd_out), 32'h2187);

    // Overwrite of slot 0, then a long dwell on digit 3.
    p0 = pulses;
    apply(7'b0010010, 4'b0001, 8);
    apply(7'b0100000, 4'b0001, 8);
    apply(7'b0000001, 4'b0010, 8);
    apply(7'b1001111, 4'b0100, 8);
    apply(7'b0000000, 4'b1000, 50);
    idle(6);
    check("ovr_pulses", 32'(pulses - p0), 32'd1);
    check("ovr_bcd", 32'(bcd_out), 32'h8106);

    // Reset mid-frame.
    apply(7'b0000100, 4'b0001, 8);
    apply(7'b0000100, 4'b0010, 8);
    seg_n = BLANK;
    dig_sel = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check("rst_async_bcd", 32'(bcd_out), 32'h0);
    check("rst_async_err", 32'(digit_err), 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_hold_fv", 32'(frame_valid), 32'h0);
    rst = 1'b0;
    p0 = pulses;
    apply(7'b0000110, 4'b0100, 8);
    apply(7'b0000110, 4'b1000, 8);
    apply(7'b0000110, 4'b0001, 8);
    idle(6);
    check("rst_no_partial", 32'(pulses - p0), 32'd0);
    apply(7'b0000110, 4'b0010, 8);
    idle(6);
    check("rst_pulses", 32'(pulses - p0), 32'd1);
    check("rst_bcd", 32'(bcd_out), 32'h3333);

    // Randomized dwells checked by the monitor against the model.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] s;
      logic [3:0] d;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)      d = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) d = 4'b0000;
      else            d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) s = 7'($urandom_range(0, 127));
      else                           s = PAT[$urandom_range(0, 9)];
      apply(s, d, $urandom_range(1, 9));
    end
    idle(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Snoops a multiplexed, active-low, common-anode 7-segment display bus (shared segment lines plus one-hot digit enables) and recovers the BCD value being shown on each digit. A glitch filter requires each pattern to be stable before it is accepted, and each pattern is decoded back to a 4-bit code. When every digit has been refreshed, one frame is published with a single-cycle valid strobe. The block is the receive end of the board's display decoder path and is used for loopback checking and display readback on the FPGA.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, range 1–8.
- `STABLE_CNT`, default 3: number of consecutive identical synchronized samples required to accept a pattern, range 2–15.
- `clk` input, 1 bit: single system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `seg_n` input, 7 bits: segments {a,b,c,d,e,f,g}, with a at bit 6. Active-low: 0 means lit. Asynchronous to `clk`.
- `dig_sel` input, DIGITS bits: digit enable, one-hot, active-high. Bit i selects digit i. Asynchronous to `clk`.
- `bcd_out` output, 4*DIGITS bits: decoded frame. Digit i occupies bits [4i+3:4i].
- `digit_err` output, DIGITS bits: per-digit flag, set when that digit's accepted pattern was not a legal code in the frame.
- `frame_valid` output, 1 bit: one-cycle pulse when `bcd_out`/`digit_err` update.

## Operation
- Synchronizer:
  - `seg_n` and `dig_sel` each pass through a 2-flop synchronizer.
  - All logic below operates on the synchronized values (`s_seg`, `s_dig`).
- Decode table (`seg_n` → code):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111 (blank)→4'hA, not an error.
  - Any other pattern→4'hF, with the error bit set.
- Stability filter:
  - Register the previous (`s_seg`, `s_dig`) pair.
  - `stab_cnt` (4 bits) increments while the pair is unchanged and `s_dig` is one-hot. It saturates at STABLE_CNT-1.
  - The counter resets to 0 on any change, or when `s_dig` is zero or multi-hot.
- Accept:
  - Fires when `stab_cnt` reaches STABLE_CNT-1 and the `taken` flag is clear.
  - Writes the code into shadow slot i and its error bit into shadow error bit i, where i is the index of `s_dig`.
  - Sets `seen[i]` and sets `taken`.
  - `taken` clears whenever `stab_cnt` resets, so each dwell is accepted exactly once.
- Re-accept of an already-seen slot before frame completion overwrites that slot (latest value wins).
- Frame completion:
  - Occurs when an accept makes `seen` all-ones.
  - On the next cycle: `bcd_out`←shadow, `digit_err`←shadow errors, `frame_valid`=1, and `seen` clears.
  - If an accept occurs in that same cycle, its slot is marked seen after the clear, so it counts toward the next frame.
- States:
  - IDLE: `seen`=0.
  - COLLECT: `seen`≠0 and not full.
  - PUBLISH: the single cycle after `seen` becomes full; returns to IDLE/COLLECT.
- Reset (async, any time, including mid-frame):
  - `bcd_out`=0, `digit_err`=0, `frame_valid`=0.
  - `seen`, `stab_cnt`, `taken`, shadow registers and synchronizers are all cleared.
  - No partial frame is published after reset.

## Timing
- An input change appears in `s_seg`/`s_dig` 2 cycles later.
- Accept occurs on the STABLE_CNT-th consecutive identical synchronized sample, i.e. 2+STABLE_CNT-1 cycles after a clean input change.
- `frame_valid` asserts exactly 1 cycle after the accept that completes the frame. It is never high in two consecutive cycles.
- `bcd_out`/`digit_err` change only in the `frame_valid` cycle and hold otherwise.
- Dwells shorter than STABLE_CNT synchronized cycles are ignored.
- Digit order is irrelevant; only coverage of all DIGITS matters.

## Test plan
1. **Clean frame.** DIGITS=4, STABLE_CNT=3. Scan digits 0..3 showing 0000110, 1001100, 0100100, 0000100, each held 8 cycles → one `frame_valid` pulse; `bcd_out`=16'h9543; `digit_err`=0.
2. **Glitch rejection.** Insert a 2-cycle 0000000 pulse on digit 1 between dwells; otherwise repeat scenario 1 → no acceptance of the 8; `bcd_out`=16'h9543.
3. **Illegal and blank patterns.** Digit 2 shows 1111110, digit 0 shows 1111111, others legal (digit 1→1001111, digit 3→0001111) → `bcd_out`=16'h7F1A; `digit_err`=4'b0100.
4. **Bad enables.** `dig_sel`=4'b0000 and 4'b0110 held 10 cycles → no accept, `seen` unchanged, no `frame_valid`.
5. **Overwrite and long dwell.**
   - Scan digit 0 twice (0010010, then 0100000) before digits 1–3 → slot 0 reads 6.
   - Hold digit 3 for 50 cycles → accepted once, exactly one pulse per frame.
6. **Reset mid-frame.** Assert `rst` after digits 0–1 are accepted, then scan all four → outputs 0 during reset; first `frame_valid` occurs only after all four digits are accepted post-reset.
